// File: rtl/register_status_file_pkg.sv
// Shared constants for the architectural register file / rename status block.
// Holds the RV32 opcode values the block decodes and the default datapath widths.
package register_status_file_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Stores and branches carry an immediate in [11:7], not a destination.
    function automatic logic opcode_writes_rd(input logic [6:0] opcode);
        return !(opcode == OP_BRANCH || opcode == OP_STORE);
    endfunction

endpackage

// File: rtl/register_status_file_reg_read_port.sv
// One combinational operand read port: x0 forcing, same-cycle commit bypass,
// otherwise the stored busy/tag/value of the addressed register.
module reg_read_port #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic [4:0]       idx,
    input  logic             commit_hit,
    input  logic [4:0]       commit_dest,
    input  logic [TAG_W-1:0] commit_rename,
    input  logic [XLEN-1:0]  commit_value,
    input  logic             stored_busy,
    input  logic [TAG_W-1:0] stored_tag,
    input  logic [XLEN-1:0]  stored_val,
    output logic             busy,
    output logic [TAG_W-1:0] tag,
    output logic [XLEN-1:0]  val
);

    // Priority: x0, then the commit that is retiring this register's producer, then storage.
    always_comb begin
        busy = stored_busy;
        tag  = stored_tag;
        val  = stored_val;
        if (idx == 5'd0) begin
            busy = 1'b0;
            tag  = '0;
            val  = '0;
        end else if (commit_hit && commit_dest == idx && stored_busy &&
                     stored_tag == commit_rename) begin
            busy = 1'b0;
            val  = commit_value;
        end
    end

endmodule

// File: rtl/register_status_file.sv
// Architectural register file with per-register rename status. Issue records the
// producing ROB tag for rd; commit writes the value and releases the rename only
// if no younger rename has replaced it. Flush drops every pending rename.
module register_status_file #(
    parameter int XLEN  = register_status_file_pkg::XLEN,
    parameter int NREG  = 32,
    parameter int TAG_W = register_status_file_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             new_ins_flag,
    input  logic [31:0]      new_ins,
    input  logic [TAG_W-1:0] rename,
    input  logic [4:0]       rename_reg,
    input  logic             commit_flag,
    input  logic [TAG_W-1:0] commit_rename,
    input  logic [4:0]       commit_dest,
    input  logic [XLEN-1:0]  commit_value,
    input  logic             commit_is_branch,
    input  logic             commit_is_store,
    input  logic             rob_flush,
    input  logic [4:0]       rs1_idx,
    input  logic [4:0]       rs2_idx,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic [TAG_W-1:0] rs1_tag,
    output logic [TAG_W-1:0] rs2_tag,
    output logic [XLEN-1:0]  rs1_val,
    output logic [XLEN-1:0]  rs2_val
);

    import register_status_file_pkg::*;

    logic [XLEN-1:0]  reg_val  [NREG];
    logic             reg_busy [NREG];
    logic [TAG_W-1:0] reg_tag  [NREG];

    logic commit_en;
    logic rename_en;
    logic unused_ins_bits;

    assign commit_en = commit_flag && (commit_dest != 5'd0) &&
                       !commit_is_branch && !commit_is_store;
    assign rename_en = new_ins_flag && (rename_reg != 5'd0) &&
                       opcode_writes_rd(new_ins[6:0]);
    assign unused_ins_bits = ^new_ins[31:7];

    // Register state update: commit first, then flush or rename override busy/tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                reg_val[i]  <= '0;
                reg_busy[i] <= 1'b0;
                reg_tag[i]  <= '0;
            end
        end else if (rdy) begin
            if (commit_en) begin
                reg_val[commit_dest] <= commit_value;
                if (reg_busy[commit_dest] && reg_tag[commit_dest] == commit_rename)
                    reg_busy[commit_dest] <= 1'b0;
            end
            if (rob_flush) begin
                for (int i = 0; i < NREG; i++)
                    reg_busy[i] <= 1'b0;
            end else if (rename_en) begin
                reg_busy[rename_reg] <= 1'b1;
                reg_tag[rename_reg]  <= rename;
            end
        end
    end

    reg_read_port #(.XLEN(XLEN), .TAG_W(TAG_W)) u_rs1 (
        .idx          (rs1_idx),
        .commit_hit   (commit_en),
        .commit_dest  (commit_dest),
        .commit_rename(commit_rename),
        .commit_value (commit_value),
        .stored_busy  (reg_busy[rs1_idx]),
        .stored_tag   (reg_tag[rs1_idx]),
        .stored_val   (reg_val[rs1_idx]),
        .busy         (rs1_busy),
        .tag          (rs1_tag),
        .val          (rs1_val)
    );

    reg_read_port #(.XLEN(XLEN), .TAG_W(TAG_W)) u_rs2 (
        .idx          (rs2_idx),
        .commit_hit   (commit_en),
        .commit_dest  (commit_dest),
        .commit_rename(commit_rename),
        .commit_value (commit_value),
        .stored_busy  (reg_busy[rs2_idx]),
        .stored_tag   (reg_tag[rs2_idx]),
        .stored_val   (reg_val[rs2_idx]),
        .busy         (rs2_busy),
        .tag          (rs2_tag),
        .val          (rs2_val)
    );

endmodule

// File: tb/tb_register_status_file.sv
// Bench for register_status_file: directed issue/commit/flush/hold/reset sequences,
// a per-register behavioural model checked on every falling edge, plus literal pins.
module tb_register_status_file;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;
    localparam logic [6:0] ADDI   = 7'b0010011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    logic             clk = 1'b0;
    logic             rst, rdy;
    logic             new_ins_flag;
    logic [31:0]      new_ins;
    logic [TAG_W-1:0] rename;
    logic [4:0]       rename_reg;
    logic             commit_flag;
    logic [TAG_W-1:0] commit_rename;
    logic [4:0]       commit_dest;
    logic [XLEN-1:0]  commit_value;
    logic             commit_is_branch, commit_is_store, rob_flush;
    logic [4:0]       rs1_idx, rs2_idx;
    logic             rs1_busy, rs2_busy;
    logic [TAG_W-1:0] rs1_tag, rs2_tag;
    logic [XLEN-1:0]  rs1_val, rs2_val;

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain per-register arrays.
    logic [XLEN-1:0]  m_val  [32];
    logic             m_busy [32];
    logic [TAG_W-1:0] m_tag  [32];
    bit               m_ok = 1'b0;

    always #5 clk = ~clk;

    register_status_file dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .new_ins_flag(new_ins_flag), .new_ins(new_ins), .rename(rename), .rename_reg(rename_reg),
        .commit_flag(commit_flag), .commit_rename(commit_rename), .commit_dest(commit_dest),
        .commit_value(commit_value), .commit_is_branch(commit_is_branch),
        .commit_is_store(commit_is_store), .rob_flush(rob_flush),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .rs1_val(rs1_val), .rs2_val(rs2_val)
    );

    function automatic bit commit_applies();
        return commit_flag && commit_dest != 5'd0 && !commit_is_branch && !commit_is_store;
    endfunction

    function automatic bit rename_applies();
        return new_ins_flag && rename_reg != 5'd0 && !rob_flush &&
               new_ins[6:0] != BRANCH && new_ins[6:0] != STORE;
    endfunction

    // Model update: each register's next status is decided from the rules independently.
    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
            end
            m_ok = 1'b1;
        end else if (rdy && m_ok) begin
            bit c_ok, r_ok;
            c_ok = commit_applies();
            r_ok = rename_applies();
            for (int r = 1; r < 32; r++) begin
                if (rob_flush)
                    m_busy[r] = 1'b0;
                else if (r_ok && r == int'(rename_reg)) begin
                    m_busy[r] = 1'b1; m_tag[r] = rename;
                end else if (c_ok && r == int'(commit_dest) && m_busy[r] && m_tag[r] == commit_rename)
                    m_busy[r] = 1'b0;
            end
            if (c_ok) m_val[commit_dest] = commit_value;
        end
    end

    task automatic expect_port(input string nm, input logic [4:0] idx, input logic b,
                               input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
        logic eb; logic [TAG_W-1:0] et; logic [XLEN-1:0] ev;
        if (idx == 5'd0) begin
            eb = 1'b0; et = '0; ev = '0;
        end else if (commit_applies() && commit_dest == idx && m_busy[idx] &&
                     m_tag[idx] == commit_rename) begin
            eb = 1'b0; et = m_tag[idx]; ev = commit_value;
        end else begin
            eb = m_busy[idx]; et = m_tag[idx]; ev = m_val[idx];
        end
        checks++;
        if (b !== eb || (!eb && v !== ev) || (eb && t !== et)) begin
            errors++;
            $display("FAIL model_%s x%0d at %0t: got busy=%b tag=%h val=%h, want busy=%b tag=%h val=%h",
                     nm, idx, $time, b, t, v, eb, et, ev);
        end
    endtask

    // Compare process: both read ports against the model on every falling edge.
    always @(negedge clk) begin
        if (m_ok && !rst) begin
            expect_port("rs1", rs1_idx, rs1_busy, rs1_tag, rs1_val);
            expect_port("rs2", rs2_idx, rs2_busy, rs2_tag, rs2_val);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rst = 1'b0; rdy = 1'b1; new_ins_flag = 1'b0; commit_flag = 1'b0;
        commit_is_branch = 1'b0; commit_is_store = 1'b0; rob_flush = 1'b0;
    endtask

    task automatic ren(input logic [4:0] rd, input logic [TAG_W-1:0] t, input logic [6:0] op);
        new_ins_flag = 1'b1; new_ins = {20'h00000, rd, op}; rename_reg = rd; rename = t;
    endtask

    task automatic cmt(input logic [4:0] d, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
        commit_flag = 1'b1; commit_dest = d; commit_rename = t; commit_value = v;
    endtask

    task automatic look(input logic [4:0] a, input logic [4:0] b);
        rs1_idx = a; rs2_idx = b;
        #2;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; new_ins_flag = 1'b0; new_ins = '0; rename = '0; rename_reg = '0;
        commit_flag = 1'b0; commit_rename = '0; commit_dest = '0; commit_value = '0;
        commit_is_branch = 1'b0; commit_is_store = 1'b0; rob_flush = 1'b0;
        rs1_idx = '0; rs2_idx = '0;
        tick();

        // Reset state
        look(5, 0);
        chk("reset_busy", {31'b0, rs1_busy}, 32'h0);
        chk("reset_tag", {28'b0, rs1_tag}, 32'h0);
        chk("reset_val", rs1_val, 32'h0);

        // Rename then commit
        ren(5, 3, ADDI); tick(); look(5, 0);
        chk("ren5_busy", {31'b0, rs1_busy}, 32'h1);
        chk("ren5_tag", {28'b0, rs1_tag}, 32'h3);
        cmt(5, 3, 32'h1234); tick(); look(5, 0);
        chk("cmt5_busy", {31'b0, rs1_busy}, 32'h0);
        chk("cmt5_val", rs1_val, 32'h1234);

        // Younger rename survives older commit
        ren(7, 2, ADDI); tick();
        ren(7, 6, ADDI); tick();
        cmt(7, 2, 32'hAA); tick(); look(7, 0);
        chk("x7_still_busy", {31'b0, rs1_busy}, 32'h1);
        chk("x7_young_tag", {28'b0, rs1_tag}, 32'h6);
        chk("model_x7_val", m_val[7], 32'hAA);
        cmt(7, 6, 32'hBB); tick(); look(7, 0);
        chk("x7_released", {31'b0, rs1_busy}, 32'h0);
        chk("x7_val", rs1_val, 32'hBB);

        // Same-cycle bypass on rs2
        ren(9, 4, ADDI); tick();
        cmt(9, 4, 32'hDEAD); look(0, 9);
        chk("bypass_busy", {31'b0, rs2_busy}, 32'h0);
        chk("bypass_val", rs2_val, 32'hDEAD);
        chk("x0_val", rs1_val, 32'h0);
        tick(); look(0, 9);
        chk("x9_after", rs2_val, 32'hDEAD);

        // Stores/branches neither rename nor write; x0 is untouchable
        ren(10, 5, STORE); tick(); look(10, 0);
        chk("store_no_ren", {31'b0, rs1_busy}, 32'h0);
        ren(10, 5, BRANCH); tick(); look(10, 0);
        chk("branch_no_ren", {31'b0, rs1_busy}, 32'h0);
        cmt(10, 5, 32'h77); commit_is_store = 1'b1; tick();
        cmt(10, 5, 32'h88); commit_is_branch = 1'b1; tick(); look(10, 0);
        chk("x10_unwritten", rs1_val, 32'h0);
        ren(0, 1, ADDI); cmt(0, 1, 32'h99); tick(); look(0, 0);
        chk("x0_busy", {31'b0, rs1_busy}, 32'h0);
        chk("x0_read", rs2_val, 32'h0);

        // Flush with simultaneous commit and ignored rename
        cmt(1, 0, 32'h11); tick();
        cmt(2, 0, 32'h22); tick();
        cmt(3, 0, 32'h33); tick();
        ren(1, 1, ADDI); tick();
        ren(2, 2, ADDI); tick();
        ren(3, 3, ADDI); tick(); look(1, 2);
        chk("pre_flush_x1", {31'b0, rs1_busy}, 32'h1);
        chk("pre_flush_x2_tag", {28'b0, rs2_tag}, 32'h2);
        rob_flush = 1'b1; cmt(4, 9, 32'h55); ren(6, 7, ADDI); tick();
        look(1, 2);
        chk("flush_x1_busy", {31'b0, rs1_busy}, 32'h0);
        chk("flush_x1_val", rs1_val, 32'h11);
        chk("flush_x2_val", rs2_val, 32'h22);
        look(3, 4);
        chk("flush_x3_busy", {31'b0, rs1_busy}, 32'h0);
        chk("flush_x4_val", rs2_val, 32'h55);
        look(6, 0);
        chk("flush_ren_ignored", {31'b0, rs1_busy}, 32'h0);

        // Hold: rdy low blocks every update but bypass still shows
        ren(12, 5, ADDI); tick();
        rdy = 1'b0; cmt(12, 5, 32'h1); ren(13, 8, ADDI); rob_flush = 1'b1; look(12, 13);
        chk("hold_bypass_busy", {31'b0, rs1_busy}, 32'h0);
        chk("hold_bypass_val", rs1_val, 32'h1);
        tick(); look(12, 13);
        chk("hold_x12_busy", {31'b0, rs1_busy}, 32'h1);
        chk("hold_x12_tag", {28'b0, rs1_tag}, 32'h5);
        chk("hold_x13_busy", {31'b0, rs2_busy}, 32'h0);
        chk("model_x12_val", m_val[12], 32'h0);

        // Reset mid-stream overrides commit/rename
        rst = 1'b1; ren(5, 1, ADDI); cmt(4, 2, 32'hFF); tick(); look(5, 12);
        chk("rst_x5_val", rs1_val, 32'h0);
        chk("rst_x12_busy", {31'b0, rs2_busy}, 32'h0);
        chk("rst_x12_tag", {28'b0, rs2_tag}, 32'h0);
        look(7, 4);
        chk("rst_x7_val", rs1_val, 32'h0);
        chk("rst_x4_val", rs2_val, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
